cam_frame_stats: RTL and testbench
==================================

# cam_frame_stats

Per-frame, per-channel pixel statistics engine for the camera/VGA pixel path: accumulates sum, maximum and minimum of every valid pixel of each colour channel during the active frame, and computes the integer mean with a shared sequential divider during vertical blanking. Results are published once every `UPDATE_FRAMES` complete frames with a one-cycle valid strobe. It generalises the earlier single-channel averager with channel/width parameters, data-enable gating, edge-triggered frame detection, min/max outputs, divide-by-zero handling and an overrun flag.

## Interface
- `PIX_W`, 8, bits per channel sample
- `CHANNELS`, 3, number of colour channels packed in `PIXEL`
- `CNT_W`, 20, pixel-count width; max pixels per frame is 2^CNT_W−1
- `UPDATE_FRAMES`, 30, publish period in complete frames (≥1)
- `VGA_CLK`  in  1  pixel clock; the single clock
- `RST`  in  1  reset, synchronous, active-high
- `V_SYNC`  in  1  high = active frame, low = vertical blanking
- `PIX_VALID`  in  1  pixel data enable
- `PIXEL`  in  CHANNELS*PIX_W  channel c at bits [c*PIX_W +: PIX_W]
- `STAT_MEAN`  out  CHANNELS*PIX_W  floor(sum/count) per channel
- `STAT_MAX`  out  CHANNELS*PIX_W  per-channel maximum
- `STAT_MIN`  out  CHANNELS*PIX_W  per-channel minimum
- `STAT_VALID`  out  1  one-cycle pulse when the STAT_* outputs update
- `OVERRUN`  out  1  sticky; a publish trigger arrived while busy

## Operation
- Accumulate when `V_SYNC`=1 and `PIX_VALID`=1: acc[c] += pixel[c] (ACC_W = PIX_W+CNT_W bits), count += 1, max/min updated.
- Frame end = `V_SYNC` falling edge (registered previous value 1, current 0). Holding `V_SYNC` low produces one event only.
- Armed flag: cleared by reset, set on first `V_SYNC` rising edge. Frame ends while unarmed are ignored, so a partial first frame is discarded.
- On an armed frame end: frame_cnt increments; at frame_cnt = UPDATE_FRAMES−1, snapshot acc/count/max/min into holding registers and set frame_cnt to 0. Live accumulators are always cleared: acc = 0, count = 0, max = 0, min = all-ones.
- FSM: S_IDLE → (snapshot) S_DIV → S_PUBLISH → S_IDLE.
- In S_DIV, channels are divided in order 0..CHANNELS−1. Each channel takes PIX_W+1 cycles: 1 load cycle plus PIX_W restoring iterations.
  - PIX_W iterations suffice because quotient ≤ max < 2^PIX_W.
  - The result is truncated (floor).
- count = 0: mean, max and min published as 0, and the divider is bypassed. The same cycle count is kept so latency stays fixed.
- Snapshot trigger while not in S_IDLE: the trigger is dropped, `OVERRUN` is set, and live accumulators still clear.

## Timing
- Reset values: `STAT_MEAN`/`STAT_MAX`/`STAT_MIN` = 0, `STAT_VALID` = 0, `OVERRUN` = 0; FSM S_IDLE; frame_cnt = 0; unarmed.
- A pixel sampled on the same edge that detects the fall (`V_SYNC`=0) is not accumulated. The pixel on the preceding edge is included.
- Snapshot taken at edge t; `STAT_VALID` high for exactly the cycle after edge t + CHANNELS·(PIX_W+1) + 1 (28 cycles for defaults).
- Outputs change only on the edge that raises `STAT_VALID` and hold until the next publish.
- `RST` mid-division: FSM to S_IDLE, no `STAT_VALID`, all outputs return to reset values.

## Structure
- Package `cam_stats_pkg`: state enum `stat_state_t` {S_IDLE, S_DIV, S_PUBLISH}; a function returning ACC_W.
- Sub-module `cam_seq_div`:
  - Parameters `NUM_W`, `DEN_W`, `Q_W`.
  - Interface: start / busy / done handshake, restoring, Q_W iterations.
  - Instantiated once and time-shared across channels.

## Test plan
- Reset: hold `RST` 2 cycles → all outputs 0, `STAT_VALID` 0, FSM S_IDLE.
- UPDATE_FRAMES=1, CHANNELS=3. After an arming rising edge, drive 100 valid pixels with ch0=100+i, ch1=i, ch2=50, then drop `V_SYNC` → one pulse 28 cycles later with:
  - mean {149, 49, 50}
  - max {199, 99, 50}
  - min {100, 0, 50}
- Gating: interleave 100 cycles of `PIX_VALID`=0 carrying 255 in the previous frame → identical results. `V_SYNC` held low 50 cycles → exactly one pulse.
- Empty frame: `V_SYNC` high 20 cycles with `PIX_VALID`=0, then low → pulse with mean/max/min all 0.
- UPDATE_FRAMES=30: start mid-frame after reset → the partial frame is ignored; the first pulse comes after the 30th complete frame end, the next 30 frames later, each reflecting only the last frame.
- Robustness:
  - Assert `RST` 5 cycles after a snapshot → no pulse, outputs 0.
  - Force a second trigger during S_DIV (UPDATE_FRAMES=1, 3-cycle frame) → `OVERRUN`=1, first result still published.

Source files
------------

// File: rtl/cam_stats_pkg.sv
// cam_stats_pkg: shared FSM state type and accumulator sizing for cam_frame_stats
package cam_stats_pkg;
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_PUBLISH} stat_state_t;
  function automatic int acc_width(input int pix_w, input int cnt_w);
    return pix_w + cnt_w;
  endfunction
endpackage

// File: rtl/cam_seq_div.sv
// cam_seq_div: restoring divider producing Q_W quotient bits, one bit per cycle
module cam_seq_div #(
  parameter int NUM_W = 28,
  parameter int DEN_W = 20,
  parameter int Q_W = 8
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic [NUM_W-1:0] num,
  input logic [DEN_W-1:0] den,
  output logic busy,
  output logic done,
  output logic [Q_W-1:0] quo
);
  localparam int CN_W = $clog2(Q_W + 1);
  logic [DEN_W-1:0] rem;
  logic [DEN_W:0] trial;
  logic ge;
  logic [CN_W-1:0] cnt;
  // quo doubles as the shift register feeding the low numerator bits in
  assign trial = {rem, quo[Q_W-1]};
  assign ge = trial >= {1'b0, den};
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        rem <= DEN_W'(num >> Q_W);
        quo <= num[Q_W-1:0];
        cnt <= CN_W'(Q_W);
        busy <= 1'b1;
      end else if (busy) begin
        rem <= ge ? DEN_W'(trial - {1'b0, den}) : DEN_W'(trial);
        quo <= (quo << 1) | Q_W'(ge);
        cnt <= cnt - 1'b1;
        if (cnt == CN_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/cam_frame_stats.sv
// cam_frame_stats: per-channel frame sum/max/min accumulation with mean computed during blanking
module cam_frame_stats
  import cam_stats_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int CHANNELS = 3,
  parameter int CNT_W = 20,
  parameter int UPDATE_FRAMES = 30
) (
  input logic VGA_CLK,
  input logic RST,
  input logic V_SYNC,
  input logic PIX_VALID,
  input logic [CHANNELS*PIX_W-1:0] PIXEL,
  output logic [CHANNELS*PIX_W-1:0] STAT_MEAN,
  output logic [CHANNELS*PIX_W-1:0] STAT_MAX,
  output logic [CHANNELS*PIX_W-1:0] STAT_MIN,
  output logic STAT_VALID,
  output logic OVERRUN
);
  localparam int ACC_W = acc_width(PIX_W, CNT_W);
  localparam int FC_W = $clog2(UPDATE_FRAMES + 1);
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int CY_W = $clog2(PIX_W + 1);
  stat_state_t state;
  logic vs_d, armed, fe, trig, div_start, div_busy, div_done;
  logic [FC_W-1:0] frame_cnt;
  logic [CH_W-1:0] ch, res_idx;
  logic [CY_W-1:0] cyc;
  logic [CNT_W-1:0] cnt, cnt_h;
  logic [PIX_W-1:0] quo;
  logic [ACC_W-1:0] acc [CHANNELS];
  logic [ACC_W-1:0] acc_h [CHANNELS];
  logic [PIX_W-1:0] pix [CHANNELS];
  logic [PIX_W-1:0] mx [CHANNELS];
  logic [PIX_W-1:0] mn [CHANNELS];
  logic [PIX_W-1:0] mx_h [CHANNELS];
  logic [PIX_W-1:0] mn_h [CHANNELS];
  logic [PIX_W-1:0] mean_q [CHANNELS];
  logic [PIX_W-1:0] mean_all [CHANNELS];
  assign fe = vs_d & ~V_SYNC;
  assign trig = fe & armed & (frame_cnt == FC_W'(UPDATE_FRAMES - 1));
  // an empty frame never starts the divider, but the cycle schedule still runs
  assign div_start = (state == S_DIV) && (cyc == '0) && (cnt_h != '0) && !div_busy;
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      pix[c] = PIXEL[c*PIX_W +: PIX_W];
      mean_all[c] = (div_done && res_idx == CH_W'(c)) ? quo : mean_q[c];
    end
  end
  cam_seq_div #(.NUM_W(ACC_W), .DEN_W(CNT_W), .Q_W(PIX_W)) u_div (
    .clk(VGA_CLK),
    .rst(RST),
    .start(div_start),
    .num(acc_h[ch]),
    .den(cnt_h),
    .busy(div_busy),
    .done(div_done),
    .quo(quo)
  );
  // vs_d resets high so a frame already running at reset release is not an arming edge
  always_ff @(posedge VGA_CLK) begin
    if (RST) begin
      vs_d <= 1'b1;
      armed <= 1'b0;
      frame_cnt <= '0;
      cnt <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc[c] <= '0;
        mx[c] <= '0;
        mn[c] <= '1;
      end
    end else begin
      vs_d <= V_SYNC;
      if (!vs_d && V_SYNC) armed <= 1'b1;
      if (fe && armed) frame_cnt <= trig ? '0 : frame_cnt + 1'b1;
      if (fe) begin
        cnt <= '0;
        for (int c = 0; c < CHANNELS; c++) begin
          acc[c] <= '0;
          mx[c] <= '0;
          mn[c] <= '1;
        end
      end else if (V_SYNC && PIX_VALID) begin
        cnt <= cnt + 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
          acc[c] <= acc[c] + ACC_W'(pix[c]);
          mx[c] <= pix[c] > mx[c] ? pix[c] : mx[c];
          mn[c] <= pix[c] < mn[c] ? pix[c] : mn[c];
        end
      end
    end
  end
  always_ff @(posedge VGA_CLK) begin
    if (RST) begin
      state <= S_IDLE;
      ch <= '0;
      cyc <= '0;
      res_idx <= '0;
      cnt_h <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc_h[c] <= '0;
        mx_h[c] <= '0;
        mn_h[c] <= '0;
        mean_q[c] <= '0;
      end
      STAT_MEAN <= '0;
      STAT_MAX <= '0;
      STAT_MIN <= '0;
      STAT_VALID <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      STAT_VALID <= 1'b0;
      if (trig && state != S_IDLE) OVERRUN <= 1'b1;
      if (div_start) res_idx <= ch;
      if (div_done) mean_q[res_idx] <= quo;
      case (state)
        S_IDLE: if (trig) begin
          state <= S_DIV;
          ch <= '0;
          cyc <= '0;
          cnt_h <= cnt;
          for (int c = 0; c < CHANNELS; c++) begin
            acc_h[c] <= acc[c];
            mx_h[c] <= mx[c];
            mn_h[c] <= mn[c];
          end
        end
        S_DIV: begin
          cyc <= cyc == CY_W'(PIX_W) ? '0 : cyc + 1'b1;
          if (cyc == CY_W'(PIX_W)) begin
            ch <= ch + 1'b1;
            if (ch == CH_W'(CHANNELS - 1)) state <= S_PUBLISH;
          end
        end
        S_PUBLISH: begin
          state <= S_IDLE;
          STAT_VALID <= 1'b1;
          for (int c = 0; c < CHANNELS; c++) begin
            STAT_MEAN[c*PIX_W +: PIX_W] <= cnt_h == '0 ? '0 : mean_all[c];
            STAT_MAX[c*PIX_W +: PIX_W] <= cnt_h == '0 ? '0 : mx_h[c];
            STAT_MIN[c*PIX_W +: PIX_W] <= cnt_h == '0 ? '0 : mn_h[c];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cam_frame_stats.sv
// tb_cam_frame_stats: table vectors, hand sequences and random frames against a frame-level reference model
module tb_cam_frame_stats;
  logic clk = 1'b0, rst = 1'b1, vs = 1'b0, pv = 1'b0;
  logic [23:0] px = '0;
  logic [23:0] mean0, max0, min0, mean1, max1, min1;
  logic v0, v1, o0, o1;
  always #5 clk = ~clk;
  cam_frame_stats #(.UPDATE_FRAMES(1)) dut0 (
    .VGA_CLK(clk), .RST(rst), .V_SYNC(vs), .PIX_VALID(pv), .PIXEL(px),
    .STAT_MEAN(mean0), .STAT_MAX(max0), .STAT_MIN(min0), .STAT_VALID(v0), .OVERRUN(o0)
  );
  cam_frame_stats #(.UPDATE_FRAMES(30)) dut1 (
    .VGA_CLK(clk), .RST(rst), .V_SYNC(vs), .PIX_VALID(pv), .PIXEL(px),
    .STAT_MEAN(mean1), .STAT_MAX(max1), .STAT_MIN(min1), .STAT_VALID(v1), .OVERRUN(o1)
  );
  typedef struct {
    int pat;
    int n;
    logic [23:0] mean;
    logic [23:0] mx;
    logic [23:0] mn;
  } vec_t;
  vec_t tbl [5];
  int cyc = 0, n_cmp = 0, n_bad = 0;
  int uf [2] = '{1, 30};
  logic m_prev = 1'b1, m_armed = 1'b0;
  longint sum [3];
  int mx [3], mn [3], cnt;
  int fcnt [2], pub_t [2], pulses [2], last_pulse [2];
  bit pend [2], e_v [2], e_ov [2];
  logic [23:0] p_mean [2], p_max [2], p_min [2], e_mean [2], e_max [2], e_min [2];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got %h want %h", nm, cyc, act, exp);
    end
  endtask
  task automatic clear_live();
    for (int c = 0; c < 3; c++) begin
      sum[c] = 0;
      mx[c] = 0;
      mn[c] = 255;
    end
    cnt = 0;
  endtask
  // frame-level view: a completed frame's statistics are due 28 edges after its end
  task automatic model_edge();
    bit fe;
    e_v = '{0, 0};
    if (rst) begin
      m_prev = 1'b1;
      m_armed = 1'b0;
      clear_live();
      for (int k = 0; k < 2; k++) begin
        fcnt[k] = 0;
        pend[k] = 0;
        e_ov[k] = 0;
        e_mean[k] = '0;
        e_max[k] = '0;
        e_min[k] = '0;
      end
      return;
    end
    fe = m_prev && !vs;
    if (fe) begin
      if (m_armed) begin
        for (int k = 0; k < 2; k++) begin
          fcnt[k]++;
          if (fcnt[k] == uf[k]) begin
            fcnt[k] = 0;
            if (pend[k]) e_ov[k] = 1;
            else begin
              pend[k] = 1;
              pub_t[k] = cyc + 28;
              for (int c = 0; c < 3; c++) begin
                p_mean[k][c*8 +: 8] = cnt == 0 ? 8'd0 : 8'(sum[c] / cnt);
                p_max[k][c*8 +: 8] = cnt == 0 ? 8'd0 : 8'(mx[c]);
                p_min[k][c*8 +: 8] = cnt == 0 ? 8'd0 : 8'(mn[c]);
              end
            end
          end
        end
      end
      clear_live();
    end else if (vs && pv) begin
      cnt++;
      for (int c = 0; c < 3; c++) begin
        int v;
        v = int'(px[c*8 +: 8]);
        sum[c] += v;
        if (v > mx[c]) mx[c] = v;
        if (v < mn[c]) mn[c] = v;
      end
    end
    if (!m_prev && vs) m_armed = 1'b1;
    m_prev = vs;
    for (int k = 0; k < 2; k++)
      if (pend[k] && cyc == pub_t[k]) begin
        pend[k] = 0;
        e_v[k] = 1;
        e_mean[k] = p_mean[k];
        e_max[k] = p_max[k];
        e_min[k] = p_min[k];
      end
  endtask
  task automatic tick(input logic r, input logic v, input logic p, input logic [23:0] d);
    rst = r;
    vs = v;
    pv = p;
    px = d;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("valid0", v0, e_v[0]);
    chk("mean0", mean0, e_mean[0]);
    chk("max0", max0, e_max[0]);
    chk("min0", min0, e_min[0]);
    chk("overrun0", o0, e_ov[0]);
    chk("valid1", v1, e_v[1]);
    chk("mean1", mean1, e_mean[1]);
    chk("max1", max1, e_max[1]);
    chk("min1", min1, e_min[1]);
    chk("overrun1", o1, e_ov[1]);
    if (v0) begin pulses[0]++; last_pulse[0] = cyc; end
    if (v1) begin pulses[1]++; last_pulse[1] = cyc; end
  endtask
  function automatic logic [23:0] pixel_of(input int pat, input int i);
    if (pat == 3) return {8'd0, 8'd255, 8'd7};
    if (pat == 4) return i == 0 ? {8'd10, 8'd1, 8'd255} : i == 1 ? {8'd20, 8'd2, 8'd254} : {8'd31, 8'd2, 8'd0};
    return {8'd50, 8'(i), 8'(100 + i)};
  endfunction
  initial begin
    int tf, b0, b1;
    tbl[0] = '{0, 100, {8'd50, 8'd49, 8'd149}, {8'd50, 8'd99, 8'd199}, {8'd50, 8'd0, 8'd100}};
    tbl[1] = '{1, 100, {8'd50, 8'd49, 8'd149}, {8'd50, 8'd99, 8'd199}, {8'd50, 8'd0, 8'd100}};
    tbl[2] = '{2, 20, 24'd0, 24'd0, 24'd0};
    tbl[3] = '{3, 1, {8'd0, 8'd255, 8'd7}, {8'd0, 8'd255, 8'd7}, {8'd0, 8'd255, 8'd7}};
    tbl[4] = '{4, 3, {8'd20, 8'd1, 8'd169}, {8'd31, 8'd2, 8'd255}, {8'd10, 8'd1, 8'd0}};
    pulses = '{0, 0};
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("reset_mean", mean0, 0);
    chk("reset_max", max0, 0);
    chk("reset_min", min0, 0);
    chk("reset_valid", v0, 0);
    chk("reset_overrun", o0, 0);
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < tbl[t].n; i++) begin
        if (tbl[t].pat == 2) tick(0, 1, 0, 24'hFFFFFF);
        else begin
          if (tbl[t].pat == 1) tick(0, 1, 0, 24'hFFFFFF);
          tick(0, 1, 1, pixel_of(tbl[t].pat, i));
        end
      end
      b0 = pulses[0];
      tick(0, 0, 0, 0);
      tf = cyc;
      for (int i = 0; i < 49; i++) tick(0, 0, 0, 0);
      chk($sformatf("tbl%0d_pulses", t), pulses[0] - b0, 1);
      chk($sformatf("tbl%0d_latency", t), last_pulse[0] - tf, 28);
      chk($sformatf("tbl%0d_mean", t), mean0, tbl[t].mean);
      chk($sformatf("tbl%0d_max", t), max0, tbl[t].mx);
      chk($sformatf("tbl%0d_min", t), min0, tbl[t].mn);
    end
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick(0, 1, 1, 24'($urandom()));
    for (int i = 0; i < 30; i++) tick(0, 0, 0, 0);
    b0 = pulses[0];
    b1 = pulses[1];
    for (int f = 0; f < 60; f++) begin
      int act, blank;
      act = $urandom_range(3, 20);
      blank = $urandom_range(30, 35);
      for (int i = 0; i < act; i++) tick(0, 1, 1'($urandom_range(0, 1)), 24'($urandom()));
      for (int i = 0; i < blank; i++) tick(0, 0, 1'($urandom_range(0, 1)), 24'($urandom()));
    end
    chk("uf1_pulses", pulses[0] - b0, 60);
    chk("uf30_pulses", pulses[1] - b1, 2);
    b0 = pulses[0];
    for (int i = 0; i < 3; i++) tick(0, 1, 1, {8'd3, 8'd2, 8'd1});
    tick(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 1, 1, {8'd9, 8'd9, 8'd9});
    for (int i = 0; i < 40; i++) tick(0, 0, 0, 0);
    chk("ovr_flag", o0, 1);
    chk("ovr_pulses", pulses[0] - b0, 1);
    chk("ovr_mean", mean0, 24'h030201);
    chk("ovr_max", max0, 24'h030201);
    b0 = pulses[0];
    for (int i = 0; i < 5; i++) tick(0, 1, 1, 24'h404040);
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) tick(0, 0, 0, 0);
    chk("rstdiv_pulses", pulses[0] - b0, 0);
    chk("rstdiv_mean", mean0, 0);
    chk("rstdiv_max", max0, 0);
    chk("rstdiv_overrun", o0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
